// File: rtl/magnitude_scheduler_pkg.sv
// Shared constants and helpers for the magnitude / threshold datapath blocks.
//
// Contents:
//   BETA_SHIFT   right-shift that realises beta = 1/4 in alpha-max-plus-beta-min
//                (alpha = 1, so the max term is used unscaled)
//   MIN_CH/MAX_CH  supported range of requesting channels for the scheduler
//   clog2_ch()   ceiling log2, used to size and cross-check channel-index fields
package magnitude_scheduler_pkg;

  localparam int unsigned BETA_SHIFT = 2;

  localparam int unsigned MIN_CH = 2;
  localparam int unsigned MAX_CH = 16;

  // Smallest r with 2**r >= n; n <= 1 gives 0.
  function automatic int unsigned clog2_ch(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/magnitude_pipe.sv
// Two-stage alpha-max-plus-beta-min magnitude datapath with a tag pass-through.
//
// Stage 1 takes |re| and |im| of the incoming sample and decides which of the two
// is the max term. Stage 2 (the output register) forms max + (min >> BETA_SHIFT).
// Both stages move together on 'advance' and hold otherwise, so the caller can
// implement output backpressure by deasserting 'advance'.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; clears every stage, data included
//   advance    1: both stages load; 0: both stages hold
//   in_valid   sample present at the input this cycle (only sampled on advance)
//   in_re      signed real part
//   in_im      signed imaginary part
//   in_tag     source channel, carried alongside the sample
//   out_valid  result valid
//   out_data   unsigned magnitude approximation, DATA_WIDTH+1 bits
//   out_tag    channel tag belonging to out_data
module magnitude_pipe
  import magnitude_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 82,
  parameter int unsigned CH_W       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic [CH_W-1:0]       in_tag,
  output logic                  out_valid,
  output logic [DATA_WIDTH:0]   out_data,
  output logic [CH_W-1:0]       out_tag
);

  // Two's-complement absolute value. The most negative input wraps to itself,
  // which read as unsigned is exactly 2**(DATA_WIDTH-1): no saturation needed.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? ((~v) + DATA_WIDTH'(1)) : v;
  endfunction

  // Stage 1 next-state
  logic [DATA_WIDTH-1:0] abs_re_d;
  logic [DATA_WIDTH-1:0] abs_im_d;
  logic                  re_is_max_d;

  // Stage 1 registers
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_abs_re_q;
  logic [DATA_WIDTH-1:0] s1_abs_im_q;
  logic                  s1_re_is_max_q;
  logic [CH_W-1:0]       s1_tag_q;

  // Stage 2 combinational
  logic [DATA_WIDTH-1:0] s2_max;
  logic [DATA_WIDTH-1:0] s2_min;
  logic [DATA_WIDTH:0]   s2_sum;

  // Stage 2 (output) registers
  logic                  s2_valid_q;
  logic [DATA_WIDTH:0]   s2_data_q;
  logic [CH_W-1:0]       s2_tag_q;

  always_comb begin
    abs_re_d    = abs_val(in_re);
    abs_im_d    = abs_val(in_im);
    // Ties pick Re as max; the result is identical either way.
    re_is_max_d = (abs_re_d >= abs_im_d);
  end

  always_comb begin
    s2_max = s1_re_is_max_q ? s1_abs_re_q : s1_abs_im_q;
    s2_min = s1_re_is_max_q ? s1_abs_im_q : s1_abs_re_q;
    // One extra bit absorbs the worst case 2**(W-1) + 2**(W-3); the shift truncates.
    s2_sum = {1'b0, s2_max} + {1'b0, s2_min >> BETA_SHIFT};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_abs_re_q    <= '0;
      s1_abs_im_q    <= '0;
      s1_re_is_max_q <= 1'b0;
      s1_tag_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_data_q      <= '0;
      s2_tag_q       <= '0;
    end else if (advance) begin
      s1_valid_q     <= in_valid;
      s1_abs_re_q    <= abs_re_d;
      s1_abs_im_q    <= abs_im_d;
      s1_re_is_max_q <= re_is_max_d;
      s1_tag_q       <= in_tag;
      s2_valid_q     <= s1_valid_q;
      s2_data_q      <= s2_sum;
      s2_tag_q       <= s1_tag_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: rtl/magnitude_scheduler.sv
// Round-robin scheduler sharing one pipelined magnitude unit between NUM_CH complex
// sample streams. Sits between the per-channel matched-filter outputs and the
// detection/threshold stage. Each result carries the index of its source channel;
// results leave in acceptance order.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; drops anything in flight
//   enable     0: no new samples are accepted; the pipeline still drains
//   reqValid   per-channel sample valid
//   reqReady   per-channel accept, one-hot or zero
//   reqDataRe  signed real parts, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqDataIm  signed imaginary parts, same packing
//   outValid   result valid
//   outReady   downstream accept
//   outData    unsigned magnitude approximation (max + min/4)
//   outChan    source channel of outData
module magnitude_scheduler
  import magnitude_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 82,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            reqValid,
  output logic [NUM_CH-1:0]            reqReady,
  input  logic [NUM_CH*DATA_WIDTH-1:0] reqDataRe,
  input  logic [NUM_CH*DATA_WIDTH-1:0] reqDataIm,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [DATA_WIDTH:0]          outData,
  output logic [CH_W-1:0]              outChan
);

  if (CH_W != clog2_ch(NUM_CH)) begin : g_bad_ch_w
    $error("magnitude_scheduler: CH_W must equal clog2(NUM_CH)");
  end

  if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("magnitude_scheduler: NUM_CH out of supported range");
  end

  logic [CH_W-1:0]       rr_ptr_q;
  logic [CH_W-1:0]       rr_ptr_d;

  logic                  advance;
  logic                  any_valid;
  logic                  accept;
  logic [CH_W-1:0]       grant;
  logic                  grant_found;
  logic [CH_W-1:0]       cand;
  logic [DATA_WIDTH-1:0] sel_re;
  logic [DATA_WIDTH-1:0] sel_im;

  // The whole pipeline moves whenever the output register is empty or being drained.
  assign advance   = !outValid || outReady;
  assign any_valid = |reqValid;

  // Round-robin search starting at rr_ptr_q; the first requester wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!grant_found && reqValid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    reqReady = '0;
    if (enable && advance && any_valid) begin
      reqReady[grant] = 1'b1;
    end
  end

  assign accept = |(reqValid & reqReady);

  // Operand mux for the granted channel.
  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_re = reqDataRe[i*DATA_WIDTH +: DATA_WIDTH];
        sel_im = reqDataIm[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves past the winner only on a real handshake, so a channel that
  // drops its request simply loses its turn.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // With no accept on an advancing cycle, in_valid=0 inserts a bubble.
  magnitude_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH_W       (CH_W)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (accept),
    .in_re     (sel_re),
    .in_im     (sel_im),
    .in_tag    (grant),
    .out_valid (outValid),
    .out_data  (outData),
    .out_tag   (outChan)
  );

endmodule

// File: tb/tb_magnitude_scheduler.sv
module tb_magnitude_scheduler;

  localparam int unsigned DW  = 82;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    reqValid;
  logic [NCH-1:0]    reqReady;
  logic [NCH*DW-1:0] reqDataRe;
  logic [NCH*DW-1:0] reqDataIm;
  logic              outValid;
  logic              outReady;
  logic [DW:0]       outData;
  logic [CHW-1:0]    outChan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  magnitude_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .CH_W       (CHW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqDataRe (reqDataRe),
    .reqDataIm (reqDataIm),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outChan   (outChan)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic signed [DW-1:0] re,
                        input logic signed [DW-1:0] im);
    reqDataRe[ch*DW +: DW] = re;
    reqDataIm[ch*DW +: DW] = im;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqValid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; reqValid = '0; outReady = 1'b1;
    reqDataRe = '0; reqDataIm = '0;
    tick(); tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d want 0", outValid); end
    n_checks++; if (outData !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", outData); end
    n_checks++; if (outChan !== '0) begin n_fail++; $display("FAIL reset_chan: got %0d want 0", outChan); end
    n_checks++; if (reqReady !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", reqReady); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_ch(0, -12, 5);
    reqValid = 4'b0001;
    #1;
    n_checks++; if (reqReady !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", reqReady); end
    tick();
    reqValid = '0;
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0d want 0", outValid); end
    tick();
    n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0d want 1", outValid); end
    n_checks++; if (outData !== 83'd13) begin n_fail++; $display("FAIL single_data: got %0d want 13", outData); end
    n_checks++; if (outChan !== 2'd0) begin n_fail++; $display("FAIL single_chan: got %0d want 0", outChan); end
    tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL single_after: got %0d want 0", outValid); end
  endtask

  task automatic test_round_robin();
    logic [DW:0] exp_rr [4];
    logic [NCH-1:0] exp_ready;
    exp_rr[0] = 83'd110; exp_rr[1] = 83'd31; exp_rr[2] = 83'd80; exp_rr[3] = 83'd3;
    do_reset();
    set_ch(0, 100, -40);
    set_ch(1, -7, -30);
    set_ch(2, 64, 64);
    set_ch(3, 0, -3);
    reqValid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_ready = 4'b0001 << (c % 4);
      n_checks++; if (reqReady !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, reqReady, exp_ready); end
      if (c >= 2) begin
        n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %0d want 1", c, outValid); end
        n_checks++; if (outChan !== CHW'((c - 2) % 4)) begin n_fail++; $display("FAIL rr_chan[%0d]: got %0d want %0d", c, outChan, (c - 2) % 4); end
        n_checks++; if (outData !== exp_rr[(c - 2) % 4]) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d want %0d", c, outData, exp_rr[(c - 2) % 4]); end
      end
      tick();
    end
    reqValid = '0;
    tick(); tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %0d want 0", outValid); end
  endtask

  task automatic test_extremes();
    logic signed [DW-1:0] minv;
    logic signed [DW-1:0] maxp;
    logic [DW:0] e1, e2, e3;
    minv = '0; minv[DW-1] = 1'b1;
    maxp = ~minv;
    e1 = (DW+1)'(1) << 81;
    e2 = e1 + ((DW+1)'(1) << 79);
    e3 = e2 - (DW+1)'(2);
    set_ch(0, minv, 0);
    reqValid = 4'b0001;
    tick();
    set_ch(0, minv, minv);
    tick();
    n_checks++; if (outData !== e1 || outValid !== 1'b1) begin n_fail++; $display("FAIL ext_min_re: got %0d want %0d", outData, e1); end
    set_ch(0, maxp, maxp);
    tick();
    n_checks++; if (outData !== e2 || outValid !== 1'b1) begin n_fail++; $display("FAIL ext_min_both: got %0d want %0d", outData, e2); end
    set_ch(0, 3, -3);
    tick();
    n_checks++; if (outData !== e3 || outValid !== 1'b1) begin n_fail++; $display("FAIL ext_max_both: got %0d want %0d", outData, e3); end
    reqValid = '0;
    tick();
    n_checks++; if (outData !== 83'd3 || outValid !== 1'b1) begin n_fail++; $display("FAIL ext_trunc: got %0d want 3", outData); end
    tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL ext_drain: got %0d want 0", outValid); end
  endtask

  task automatic test_stall();
    do_reset();
    set_ch(0, 100, -40);
    set_ch(1, 20, 8);
    set_ch(2, -40, 4);
    set_ch(3, 0, -3);
    reqValid = 4'b0110;
    #1;
    n_checks++; if (reqReady !== 4'b0010) begin n_fail++; $display("FAIL stall_g1: got %b want 0010", reqReady); end
    tick();
    n_checks++; if (reqReady !== 4'b0100) begin n_fail++; $display("FAIL stall_g2: got %b want 0100", reqReady); end
    tick();
    reqValid = 4'b1111;
    outReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (outValid !== 1'b1 || outData !== 83'd22 || outChan !== 2'd1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%0d d=%0d ch=%0d want v=1 d=22 ch=1", c, outValid, outData, outChan);
      end
      n_checks++; if (reqReady !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, reqReady); end
      tick();
    end
    outReady = 1'b1;
    reqValid = 4'b1000;
    #1;
    n_checks++; if (reqReady !== 4'b1000) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1000", reqReady); end
    tick();
    reqValid = '0;
    n_checks++; if (outValid !== 1'b1 || outData !== 83'd41 || outChan !== 2'd2) begin
      n_fail++; $display("FAIL stall_second: got v=%0d d=%0d ch=%0d want v=1 d=41 ch=2", outValid, outData, outChan);
    end
    tick();
    n_checks++; if (outValid !== 1'b1 || outData !== 83'd3 || outChan !== 2'd3) begin
      n_fail++; $display("FAIL stall_third: got v=%0d d=%0d ch=%0d want v=1 d=3 ch=3", outValid, outData, outChan);
    end
    tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL stall_dup: got %0d want 0", outValid); end
  endtask

  task automatic test_enable_rr_ptr();
    do_reset();
    reqValid = 4'b0100;
    #1;
    n_checks++; if (reqReady !== 4'b0100) begin n_fail++; $display("FAIL en_g_ch2a: got %b want 0100", reqReady); end
    tick();
    n_checks++; if (reqReady !== 4'b0100) begin n_fail++; $display("FAIL en_g_ch2_wrap: got %b want 0100", reqReady); end
    tick();
    reqValid = 4'b1111;
    #1;
    n_checks++; if (reqReady !== 4'b1000) begin n_fail++; $display("FAIL en_ptr_kept: got %b want 1000", reqReady); end
    n_checks++; if (outValid !== 1'b1 || outChan !== 2'd2 || outData !== 83'd41) begin
      n_fail++; $display("FAIL en_out1: got v=%0d d=%0d ch=%0d want v=1 d=41 ch=2", outValid, outData, outChan);
    end
    tick();
    enable = 1'b0;
    #1;
    n_checks++; if (reqReady !== 4'b0000) begin n_fail++; $display("FAIL en_off_ready: got %b want 0000", reqReady); end
    n_checks++; if (outValid !== 1'b1 || outChan !== 2'd2 || outData !== 83'd41) begin
      n_fail++; $display("FAIL en_out2: got v=%0d d=%0d ch=%0d want v=1 d=41 ch=2", outValid, outData, outChan);
    end
    tick();
    n_checks++; if (outValid !== 1'b1 || outChan !== 2'd3 || outData !== 83'd3) begin
      n_fail++; $display("FAIL en_out3: got v=%0d d=%0d ch=%0d want v=1 d=3 ch=3", outValid, outData, outChan);
    end
    tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL en_empty: got %0d want 0", outValid); end
    enable = 1'b1;
    #1;
    n_checks++; if (reqReady !== 4'b0001) begin n_fail++; $display("FAIL en_resume: got %b want 0001", reqReady); end
    reqValid = '0;
    tick();
  endtask

  task automatic test_reset_flush();
    reqValid = 4'b1111;
    tick();
    tick();
    n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL flush_loaded: got %0d want 1", outValid); end
    reset = 1'b1;
    reqValid = '0;
    tick();
    n_checks++; if (outValid !== 1'b0 || outData !== '0 || outChan !== '0) begin
      n_fail++; $display("FAIL flush_cleared: got v=%0d d=%0d ch=%0d want 0", outValid, outData, outChan);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL flush_stale[%0d]: got %0d want 0", c, outValid); end
    end
    reqValid = 4'b1111;
    #1;
    n_checks++; if (reqReady !== 4'b0001) begin n_fail++; $display("FAIL flush_ptr: got %b want 0001", reqReady); end
    reqValid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_stall();
    test_enable_rr_ptr();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
